// File: rtl/fc_seq_pkg.sv
// Shared types and pipeline latencies for the fully connected layer sequencer.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    BIAS,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  // Weight ROM read plus multiplier output register.
  localparam int MAC_PIPE_LAT = 2;
  // Registered read of the bias ROM.
  localparam int ROM_LAT = 1;

endpackage

// File: rtl/fc_seq_delay_line.sv
// Fixed-depth single-bit shift register used to align control strobes with datapath latency.
module fc_seq_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  // NOTE: sequential state is updated with non-blocking assignments so every stage
  // samples its neighbour's old value and the shift order is irrelevant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Control path for one M x N fully connected layer: loads x, sequences bias/MAC/drain/output per row.
// Optional double-buffered x RAM when FC_SEQ_XBUF_EN is defined.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int LOGM = $clog2(M),
  parameter int LOGN = $clog2(N),
  parameter int LOGW = $clog2(M*N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            m_ready,
  output logic            m_valid,
  output logic            wr_en_x,
  output logic [LOGN-1:0] addr_x,
  output logic            x_bank,
  output logic [LOGW-1:0] addr_w,
  output logic [LOGM-1:0] addr_b,
  output logic            acc_clear,
  output logic            mac_en,
  output logic            y_load,
  output logic            busy
);

  localparam int LCW = LOGN + 1;
  localparam logic [LOGN:0]   N_LAST     = LCW'(N - 1);
  localparam logic [LOGN-1:0] K_LAST     = LOGN'(N - 1);
  localparam logic [LOGN-1:0] DRAIN_LAST = LOGN'(MAC_PIPE_LAT - 1);
  localparam logic [LOGM-1:0] ROW_LAST   = LOGM'(M - 1);

  state_t          state_q, state_d;
  logic [LOGM-1:0] row_q;
  logic [LOGN-1:0] k_q;
  logic [LOGN:0]   load_cnt_q;
  logic            m_valid_q;
  logic            last_row;
  logic            bias_now;
  logic            issue_now;

`ifdef FC_SEQ_XBUF_EN
  localparam logic [LOGN:0] N_CNT = LCW'(N);
  logic bank_q;
  logic shadow_wr;
`endif

  assign last_row  = (row_q == ROW_LAST);
  assign bias_now  = (state_q == BIAS);
  assign issue_now = (state_q == MAC);

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    wr_en_x = 1'b0;
    addr_x  = '0;
    y_load  = 1'b0;
`ifdef FC_SEQ_XBUF_EN
    shadow_wr = 1'b0;
    // MAC owns addr_x for reads, so shadow-bank writes are taken in the other compute states.
    if (state_q inside {BIAS, DRAIN, OUT, DONE}) begin
      s_ready   = (load_cnt_q != N_CNT);
      wr_en_x   = s_valid && s_ready;
      addr_x    = load_cnt_q[LOGN-1:0];
      shadow_wr = wr_en_x;
    end
`endif
    case (state_q)
      IDLE, LOAD_X: begin
        // Gating with reset keeps every output at 0 while reset is held.
        s_ready = reset;
        wr_en_x = s_valid && s_ready;
        addr_x  = load_cnt_q[LOGN-1:0];
        if (wr_en_x) begin
          state_d = (load_cnt_q == N_LAST) ? BIAS : LOAD_X;
        end
      end
      BIAS: state_d = MAC;
      MAC: begin
        addr_x = k_q;
        if (k_q == K_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (k_q == DRAIN_LAST) state_d = OUT;
      end
      OUT: begin
        if (!m_valid_q || m_ready) begin
          y_load = 1'b1;
          if (!last_row) begin
            state_d = BIAS;
          end else begin
`ifdef FC_SEQ_XBUF_EN
            state_d = ((load_cnt_q + LCW'(wr_en_x)) == N_CNT) ? BIAS : LOAD_X;
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
        if (m_valid_q && m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q      <= '0;
      k_q        <= '0;
      load_cnt_q <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      // A new vector starts computing: the (shadow) load count restarts from 0.
      if ((state_q == LOAD_X || (state_q == OUT && last_row)) && state_d == BIAS) begin
        load_cnt_q <= '0;
      end else if (wr_en_x) begin
        load_cnt_q <= load_cnt_q + LCW'(1);
      end

      if (y_load) begin
        row_q <= last_row ? '0 : row_q + LOGM'(1);
      end

      // k doubles as the drain counter; it restarts whenever MAC or DRAIN is left.
      if (state_q inside {MAC, DRAIN}) begin
        k_q <= (state_d != state_q) ? '0 : k_q + LOGN'(1);
      end

      if (y_load) begin
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

`ifdef FC_SEQ_XBUF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q <= 1'b0;
    end else if (y_load && last_row) begin
      bank_q <= ~bank_q;
    end
  end

  // Reads and LOAD_X writes use the active bank; compute-time writes target the other one.
  assign x_bank = bank_q ^ shadow_wr;
`else
  assign x_bank = 1'b0;
`endif

  fc_seq_delay_line #(.DEPTH(ROM_LAT)) u_clear_dly (
    .clk   (clk),
    .reset (reset),
    .din   (bias_now),
    .dout  (acc_clear)
  );

  fc_seq_delay_line #(.DEPTH(MAC_PIPE_LAT)) u_mac_dly (
    .clk   (clk),
    .reset (reset),
    .din   (issue_now),
    .dout  (mac_en)
  );

  assign addr_w  = issue_now ? (LOGW'(row_q) * LOGW'(N) + LOGW'(k_q)) : '0;
  assign addr_b  = row_q;
  assign m_valid = m_valid_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed self-checking bench for fc_layer_sequencer (default build, M=8, N=8).
module tb_fc_layer_sequencer;

  localparam int M    = 8;
  localparam int N    = 8;
  localparam int LOGM = 3;
  localparam int LOGN = 3;
  localparam int LOGW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_valid;
  logic            s_ready;
  logic            m_ready;
  logic            m_valid;
  logic            wr_en_x;
  logic [LOGN-1:0] addr_x;
  logic            x_bank;
  logic [LOGW-1:0] addr_w;
  logic [LOGM-1:0] addr_b;
  logic            acc_clear;
  logic            mac_en;
  logic            y_load;
  logic            busy;
  logic [7:0]      ctl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fc_layer_sequencer #(.M(M), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .wr_en_x   (wr_en_x),
    .addr_x    (addr_x),
    .x_bank    (x_bank),
    .addr_w    (addr_w),
    .addr_b    (addr_b),
    .acc_clear (acc_clear),
    .mac_en    (mac_en),
    .y_load    (y_load),
    .busy      (busy)
  );

  assign ctl = {busy, s_ready, wr_en_x, acc_clear, mac_en, y_load, m_valid, x_bank};

  function automatic logic [7:0] ctl_exp(input bit b, input bit sr, input bit we, input bit ac,
                                         input bit me, input bit yl, input bit mv);
    return {b, sr, we, ac, me, yl, mv, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Streams N words; ends one cycle after the N-th accept, which must be BIAS.
  task automatic load_vector(input bit toggle);
    int cnt;
    int cyc;
    cnt = 0;
    cyc = 0;
    m_ready = 1'b1;
    while (cnt < N && cyc < 64) begin
      s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      check($sformatf("load_ctl cyc=%0d", cyc), 32'(ctl),
            32'(ctl_exp(cnt != 0, 1'b1, s_valid, 1'b0, 1'b0, 1'b0, 1'b0)));
      if (s_valid) begin
        check($sformatf("load_addr_x cyc=%0d", cyc), 32'(addr_x), 32'(cnt));
        cnt++;
      end
      next_cycle();
      cyc++;
    end
    s_valid = 1'b0;
    if (cnt != N) begin
      n_vec++;
      n_err++;
      $error("FAIL load_timeout: observed %0d words expected %0d", cnt, N);
    end
  endtask

  // Cycle c=1 is the cycle after the last accept. m_ready is low for c in [lo,hi].
  task automatic run_compute(input int lo, input int hi, input int abort_at,
                             input logic sv_hold, output bit aborted);
    int row;
    int t0;
    int rel;
    int ycount;
    bit mv;
    bit done_ph;
    bit exp_y;
    bit mr;
    row = 0;
    t0 = 1;
    mv = 1'b0;
    done_ph = 1'b0;
    ycount = 0;
    aborted = 1'b0;
    for (int c = 1; c < 400; c++) begin
      if (c == abort_at) begin
        aborted = 1'b1;
        return;
      end
      mr = !(c >= lo && c <= hi);
      m_ready = mr;
      s_valid = sv_hold;
      #1;
      rel = c - t0;
      exp_y = !done_ph && rel >= N + 3 && (!mv || mr);
      check($sformatf("ctl c=%0d", c), 32'(ctl),
            32'(ctl_exp(1'b1, 1'b0, 1'b0, !done_ph && rel == 1,
                        !done_ph && rel >= 3 && rel <= N + 2, exp_y, mv)));
      if (!done_ph && rel == 0)
        check($sformatf("addr_b c=%0d", c), 32'(addr_b), 32'(row));
      if (!done_ph && rel >= 1 && rel <= N) begin
        check($sformatf("addr_w c=%0d", c), 32'(addr_w), 32'(row * N + rel - 1));
        check($sformatf("addr_x c=%0d", c), 32'(addr_x), 32'(rel - 1));
      end
      if (y_load === 1'b1) ycount++;
      if (done_ph && mv && mr) begin
        next_cycle();
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        check("idle_ctl", 32'(ctl), 32'(ctl_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        check("y_count", 32'(ycount), 32'(M));
        return;
      end
      if (mv && mr) mv = 1'b0;
      if (exp_y) begin
        mv = 1'b1;
        if (row == M - 1) done_ph = 1'b1;
        else begin
          row++;
          t0 = c + 1;
        end
      end
      next_cycle();
    end
    n_vec++;
    n_err++;
    $error("FAIL run_timeout: observed busy=%0b expected return to IDLE", busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    reset = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #3;
    check("reset_ctl", 32'(ctl), 32'(0));
    check("reset_addr", 32'({addr_x, addr_w, addr_b}), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("release_ctl", 32'(ctl), 32'(ctl_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));

    // Back-to-back load, no backpressure.
    load_vector(1'b0);
    run_compute(0, -1, 0, 1'b0, ab);

    // Output stalled 20 cycles from first m_valid; s_valid held high during compute.
    load_vector(1'b0);
    run_compute(13, 32, 0, 1'b1, ab);

    // Gapped input, then final word held in DONE for 5 cycles.
    load_vector(1'b1);
    run_compute(97, 101, 0, 1'b0, ab);

    // Reset during MAC of row 3 (c=40), released two cycles later.
    load_vector(1'b0);
    run_compute(0, -1, 40, 1'b0, ab);
    reset = 1'b0;
    #1;
    check("abort_ctl", 32'(ctl), 32'(0));
    check("abort_addr", 32'({addr_x, addr_w, addr_b}), 32'(0));
    next_cycle();
    check("abort_hold_ctl", 32'(ctl), 32'(0));
    next_cycle();
    reset = 1'b1;
    #1;
    check("rerelease_ctl", 32'(ctl), 32'(ctl_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));

    // Full sequence after the abort.
    load_vector(1'b0);
    run_compute(0, -1, 0, 1'b0, ab);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
